// File: rtl/cpu_pkg.sv
// Shared encodings and constants for the decode/operand-fetch pipeline slice.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cpu_pkg;

  // Write-back source select
  localparam logic [1:0] MD_ALU = 2'd0;
  localparam logic [1:0] MD_MEM = 2'd1;
  localparam logic [1:0] MD_SLT = 2'd2;

  // Branch select
  localparam logic [1:0] BS_NONE = 2'd0;
  localparam logic [1:0] BS_Z    = 2'd1;
  localparam logic [1:0] BS_NZ   = 2'd2;
  localparam logic [1:0] BS_JMP  = 2'd3;

  // Register 0 is hard-wired zero and is never a forwarding target
  localparam int REG_ZERO = 0;

  // Immediate field width
  localparam int IMM_BITS = 16;

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Registered DOF -> execute bundle: controls, operands, PC and squash flag.
// Latency: n/a (wires only; driver registers every field).
// Backpressure: none; execute consumes one bundle per cycle.
interface operand_fetch_stage_if #(
  parameter int DATA_BITS             = 32,
  parameter int reg_addr_width        = 5,
  parameter int PROGRAM_COUNTER_WIDTH = 32
);

  logic                             RW;
  logic [reg_addr_width-1:0]        DA;
  logic [1:0]                       MD;
  logic [1:0]                       BS;
  logic                             PS;
  logic                             MW;
  logic [3:0]                       FS;
  logic [reg_addr_width-1:0]        SH;
  logic [DATA_BITS-1:0]             BUSA;
  logic [DATA_BITS-1:0]             BUSB;
  logic [PROGRAM_COUNTER_WIDTH-1:0] pc_min_two;
  logic                             squash;

  // DOF stage drives the bundle
  modport master (
    output RW, DA, MD, BS, PS, MW, FS, SH, BUSA, BUSB, pc_min_two, squash
  );

  // Execute stage consumes the bundle
  modport slave (
    input RW, DA, MD, BS, PS, MW, FS, SH, BUSA, BUSB, pc_min_two, squash
  );

endinterface

// File: rtl/operand_fetch_stage_forward.sv
// Priority forwarding mux for one source operand: EX over WB over register file.
// Latency: combinational.
// Backpressure: none.
module operand_forward
  import cpu_pkg::*;
#(
  parameter int DATA_BITS      = 32,
  parameter int reg_addr_width = 5
) (
  input  logic [reg_addr_width-1:0] src_addr,
  input  logic [DATA_BITS-1:0]      rf_data,
  input  logic                      ex_rw,
  input  logic [reg_addr_width-1:0] ex_da,
  input  logic [DATA_BITS-1:0]      ex_data,
  input  logic                      wb_rw,
  input  logic [reg_addr_width-1:0] wb_da,
  input  logic [DATA_BITS-1:0]      wb_data,
  output logic [DATA_BITS-1:0]      fwd_data
);

  logic src_nonzero;
  logic ex_hit;
  logic wb_hit;

  // Youngest producer wins; register 0 always reads the file value
  always_comb begin
    src_nonzero = (src_addr != reg_addr_width'(REG_ZERO));
    ex_hit      = ex_rw && (ex_da == src_addr) && src_nonzero;
    wb_hit      = wb_rw && (wb_da == src_addr) && src_nonzero;
    fwd_data    = rf_data;
    if (ex_hit) begin
      fwd_data = ex_data;
    end else if (wb_hit) begin
      fwd_data = wb_data;
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode/operand-fetch stage: forwards, builds BUSA/BUSB and registers controls for execute.
// Latency: one cycle, all outputs registered.
// Backpressure: none; wrong-path instructions after a taken branch become bubbles.
module operand_fetch_stage
  import cpu_pkg::*;
#(
  parameter int DATA_BITS             = 32,
  parameter int reg_addr_width        = 5,
  parameter int PROGRAM_COUNTER_WIDTH = 32,
  parameter int BRANCH_SHADOW         = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             valid_in,
  input  logic                             RW_in,
  input  logic [reg_addr_width-1:0]        DA_in,
  input  logic [reg_addr_width-1:0]        AA,
  input  logic [reg_addr_width-1:0]        BA,
  input  logic [1:0]                       MD_in,
  input  logic [1:0]                       BS_in,
  input  logic                             PS_in,
  input  logic                             MW_in,
  input  logic [3:0]                       FS_in,
  input  logic [reg_addr_width-1:0]        SH_in,
  input  logic                             MA,
  input  logic                             MB,
  input  logic                             CS,
  input  logic [IMM_BITS-1:0]              imm,
  input  logic [PROGRAM_COUNTER_WIDTH-1:0] pc_in,
  input  logic [DATA_BITS-1:0]             A_data,
  input  logic [DATA_BITS-1:0]             B_data,
  input  logic                             ex_RW,
  input  logic [reg_addr_width-1:0]        ex_DA,
  input  logic [DATA_BITS-1:0]             ex_forward,
  input  logic                             wb_RW,
  input  logic [reg_addr_width-1:0]        wb_DA,
  input  logic [DATA_BITS-1:0]             wb_data,
  input  logic                             br_taken,
  operand_fetch_stage_if.master            ex_out
);

  localparam int CNT_W = $clog2(BRANCH_SHADOW + 1);
  // The branch cycle itself squashes the current instruction, so the
  // counter only has to cover the remaining shadow slots.
  localparam logic [CNT_W-1:0] SHADOW_RELOAD = CNT_W'(BRANCH_SHADOW - 1);

  logic [DATA_BITS-1:0] fwd_a;
  logic [DATA_BITS-1:0] fwd_b;

  operand_forward #(
    .DATA_BITS      (DATA_BITS),
    .reg_addr_width (reg_addr_width)
  ) u_fwd_a (
    .src_addr (AA),
    .rf_data  (A_data),
    .ex_rw    (ex_RW),
    .ex_da    (ex_DA),
    .ex_data  (ex_forward),
    .wb_rw    (wb_RW),
    .wb_da    (wb_DA),
    .wb_data  (wb_data),
    .fwd_data (fwd_a)
  );

  operand_forward #(
    .DATA_BITS      (DATA_BITS),
    .reg_addr_width (reg_addr_width)
  ) u_fwd_b (
    .src_addr (BA),
    .rf_data  (B_data),
    .ex_rw    (ex_RW),
    .ex_da    (ex_DA),
    .ex_data  (ex_forward),
    .wb_rw    (wb_RW),
    .wb_da    (wb_DA),
    .wb_data  (wb_data),
    .fwd_data (fwd_b)
  );

  logic                             rw_q, rw_d;
  logic [reg_addr_width-1:0]        da_q, da_d;
  logic [1:0]                       md_q, md_d;
  logic [1:0]                       bs_q, bs_d;
  logic                             ps_q, ps_d;
  logic                             mw_q, mw_d;
  logic [3:0]                       fs_q, fs_d;
  logic [reg_addr_width-1:0]        sh_q, sh_d;
  logic [DATA_BITS-1:0]             busa_q, busa_d;
  logic [DATA_BITS-1:0]             busb_q, busb_d;
  logic [PROGRAM_COUNTER_WIDTH-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]                 shadow_q, shadow_d;

  logic                 squash_now;
  logic                 bubble;
  logic [DATA_BITS-1:0] imm_sext;
  logic [DATA_BITS-1:0] imm_zext;
  logic [DATA_BITS-1:0] pc_ext;

  // Shadow counter, bubble decision and next-state of every execute field
  always_comb begin
    squash_now = br_taken || (shadow_q != '0);
    bubble     = !valid_in || squash_now;

    shadow_d = shadow_q;
    if (br_taken) begin
      shadow_d = SHADOW_RELOAD;
    end else if (shadow_q != '0) begin
      shadow_d = shadow_q - CNT_W'(1);
    end

    imm_sext = DATA_BITS'($signed(imm));
    imm_zext = DATA_BITS'(imm);
    pc_ext   = DATA_BITS'(pc_in);

    busa_d = MA ? pc_ext : fwd_a;
    busb_d = MB ? (CS ? imm_sext : imm_zext) : fwd_b;
    pc_d   = pc_in;

    // Bubbles only need their side-effecting controls cleared
    rw_d = bubble ? 1'b0 : RW_in;
    mw_d = bubble ? 1'b0 : MW_in;
    bs_d = bubble ? BS_NONE : BS_in;
    da_d = DA_in;
    md_d = MD_in;
    ps_d = PS_in;
    fs_d = FS_in;
    sh_d = SH_in;
  end

  // Pipeline register into execute; reset also clears a pending branch shadow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rw_q     <= 1'b0;
      da_q     <= '0;
      md_q     <= MD_ALU;
      bs_q     <= BS_NONE;
      ps_q     <= 1'b0;
      mw_q     <= 1'b0;
      fs_q     <= '0;
      sh_q     <= '0;
      busa_q   <= '0;
      busb_q   <= '0;
      pc_q     <= '0;
      shadow_q <= '0;
    end else begin
      rw_q     <= rw_d;
      da_q     <= da_d;
      md_q     <= md_d;
      bs_q     <= bs_d;
      ps_q     <= ps_d;
      mw_q     <= mw_d;
      fs_q     <= fs_d;
      sh_q     <= sh_d;
      busa_q   <= busa_d;
      busb_q   <= busb_d;
      pc_q     <= pc_d;
      shadow_q <= shadow_d;
    end
  end

  assign ex_out.RW         = rw_q;
  assign ex_out.DA         = da_q;
  assign ex_out.MD         = md_q;
  assign ex_out.BS         = bs_q;
  assign ex_out.PS         = ps_q;
  assign ex_out.MW         = mw_q;
  assign ex_out.FS         = fs_q;
  assign ex_out.SH         = sh_q;
  assign ex_out.BUSA       = busa_q;
  assign ex_out.BUSB       = busb_q;
  assign ex_out.pc_min_two = pc_q;
  assign ex_out.squash     = (shadow_q != '0);

endmodule
